// File: rtl/div_issue_unit_pkg.sv
// Shared definitions for the divider issue sequencer: FSM state encoding and
// the MIPS funct codes main control decodes to raise req.
package div_issue_unit_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FIX   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    FIX   = ST_FIX
  } state_t;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

endpackage

// File: rtl/div_issue_unit_abs_conv.sv
// Two's-complement magnitude: negates negative values when is_signed is set,
// otherwise passes the operand through unchanged.
module abs_conv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] val,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] mag
);

  assign mag = (is_signed && val[DATA_WIDTH-1]) ? (~val + 1'b1) : val;

endmodule

// File: rtl/div_issue_unit.sv
// Sequencer around the iterative divider: issues the start pulse, stalls the
// core, sign-corrects the quotient into LO. Optional macro: DIV_ZERO_DETECT_EN.
module div_issue_unit
  import div_issue_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_op1,
  output logic [DATA_WIDTH-1:0] div_op2,
  input  logic [DATA_WIDTH-1:0] div_result,
  input  logic                  div_done,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  div_zero
);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   op1_reg, op1_next;
  logic [DATA_WIDTH-1:0]   op2_reg, op2_next;
  logic [DATA_WIDTH-1:0]   q_reg, q_next;
  logic [DATA_WIDTH-1:0]   lo_reg, lo_next;
  logic                    neg_q_reg, neg_q_next;
  logic                    start_reg, start_next;
  logic                    stall_reg, stall_next;
  logic                    zero_reg, zero_next;
  logic [DATA_WIDTH-1:0]   rs_mag, rt_mag;

  abs_conv #(.DATA_WIDTH(DATA_WIDTH)) u_abs_rs (
    .val       (rs_val),
    .is_signed (is_signed),
    .mag       (rs_mag)
  );

  abs_conv #(.DATA_WIDTH(DATA_WIDTH)) u_abs_rt (
    .val       (rt_val),
    .is_signed (is_signed),
    .mag       (rt_mag)
  );

  always_comb begin
    state_next = state_reg;
    op1_next   = op1_reg;
    op2_next   = op2_reg;
    q_next     = q_reg;
    lo_next    = lo_reg;
    neg_q_next = neg_q_reg;
    zero_next  = zero_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          op1_next   = rs_mag;
          op2_next   = rt_mag;
          neg_q_next = is_signed & (rs_val[DATA_WIDTH-1] ^ rt_val[DATA_WIDTH-1]);
          state_next = ISSUE;
`ifdef DIV_ZERO_DETECT_EN
          // Zero divisor bypasses the divider and forces an all-ones quotient
          if (rt_val == '0) begin
            q_next     = '1;
            neg_q_next = 1'b0;
            zero_next  = 1'b1;
            state_next = FIX;
          end
`endif
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (div_done) begin
          q_next     = div_result;
          state_next = FIX;
        end
      end
      FIX: begin
        lo_next    = neg_q_reg ? (~q_reg + 1'b1) : q_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Registered outputs follow the state being entered
    start_next = (state_next == ISSUE);
    stall_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op1_reg   <= '0;
      op2_reg   <= '0;
      q_reg     <= '0;
      lo_reg    <= '0;
      neg_q_reg <= 1'b0;
      start_reg <= 1'b0;
      stall_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      op1_reg   <= op1_next;
      op2_reg   <= op2_next;
      q_reg     <= q_next;
      lo_reg    <= lo_next;
      neg_q_reg <= neg_q_next;
      start_reg <= start_next;
      stall_reg <= stall_next;
      zero_reg  <= zero_next;
    end
  end

  assign div_start = start_reg;
  assign div_op1   = op1_reg;
  assign div_op2   = op2_reg;
  assign stall     = stall_reg;
  assign lo_out    = lo_reg;
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero  = zero_reg;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_unit.sv
// Randomized self-checking bench for div_issue_unit with a behavioural divider
// and an arithmetic reference model for magnitudes and quotients.
module tb_div_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        div_start;
  logic [31:0] div_op1, div_op2;
  logic [31:0] div_result = '0;
  logic        div_done = 1'b0;
  logic        stall;
  logic [31:0] lo_out;
  logic        div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  // Divider model controls and state (not reset by the DUT reset on purpose)
  int          lat_cfg = 3;
  int          hold_cfg = 1;
  int          starts = 0;
  int          dcount = 0;
  int          hold = 0;
  logic        busy = 1'b0;
  logic [31:0] dres = '0;

  always #5 clk = ~clk;

  div_issue_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .is_signed  (is_signed),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .div_start  (div_start),
    .div_op1    (div_op1),
    .div_op2    (div_op2),
    .div_result (div_result),
    .div_done   (div_done),
    .stall      (stall),
    .lo_out     (lo_out),
    .div_zero   (div_zero)
  );

  always @(posedge clk) begin
    if (div_start) begin
      starts   <= starts + 1;
      busy     <= 1'b1;
      dcount   <= lat_cfg;
      dres     <= (div_op2 == 0) ? 32'hFFFF_FFFF : div_op1 / div_op2;
      div_done <= 1'b0;
    end else if (busy) begin
      if (dcount <= 1) begin
        busy       <= 1'b0;
        div_done   <= 1'b1;
        div_result <= dres;
        hold       <= hold_cfg - 1;
      end else begin
        dcount <= dcount - 1;
      end
    end else if (hold > 0) begin
      hold <= hold - 1;
    end else begin
      div_done <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mag(input logic [31:0] x, input logic sgn);
    longint v;
    v = sgn ? longint'($signed(x)) : longint'(x);
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint q;
    if (b == 0) return 32'hFFFF_FFFF;
    if (sgn) q = longint'($signed(a)) / longint'($signed(b));
    else     q = longint'(a) / longint'(b);
    return q[31:0];
  endfunction

  // One DIV/DIVU transaction; optionally a spurious req while stalled
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int lat, input int hld, input bit extra_req);
    logic [31:0] exp_q, lo_before;
    int s0, cyc;
    bit seen;
    lat_cfg  = lat;
    hold_cfg = hld;
    exp_q    = ref_quot(a, b, sgn);
    lo_before = lo_out;
    @(negedge clk);
    req = 1'b1; rs_val = a; rt_val = b; is_signed = sgn;
    @(negedge clk);
    req = 1'b0; rs_val = $urandom; rt_val = $urandom;
    check_eq("stall_rise", {31'd0, stall}, 32'd1);
    check_eq("start_pulse", {31'd0, div_start}, 32'd1);
    check_eq("op1", div_op1, ref_mag(a, sgn));
    check_eq("op2", div_op2, ref_mag(b, sgn));
    check_eq("lo_hold", lo_out, lo_before);
    s0 = starts;
    if (extra_req) begin
      @(negedge clk);
      req = 1'b1; is_signed = ~sgn;
      @(negedge clk);
      req = 1'b0;
    end
    seen = 1'b0;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (!stall) begin seen = 1'b1; break; end
    end
    check_eq("stall_drop", {31'd0, seen}, 32'd1);
    check_eq("lo", lo_out, exp_q);
    check_eq("one_start", starts, s0 + 1);
    repeat (4) @(negedge clk);
    check_eq("no_rewrite", lo_out, exp_q);
    check_eq("idle_stall", {31'd0, stall}, 32'd0);
    $display("op rs=%08h rt=%08h signed=%0d lat=%0d hold=%0d xreq=%0d -> lo=%08h exp=%08h",
             a, b, sgn, lat, hld, extra_req, lo_out, exp_q);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int s0;
    bit seen;
    #2;
    check_eq("rst_start", {31'd0, div_start}, 32'd0);
    check_eq("rst_op1", div_op1, 32'd0);
    check_eq("rst_op2", div_op2, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_lo", lo_out, 32'd0);
    check_eq("rst_zero", {31'd0, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 3, 1, 1'b0);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 2, 1, 1'b0);
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 4, 1, 1'b0);
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1, 1, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5, 1, 1'b0);
    check_eq("ovf_zero", {31'd0, div_zero}, 32'd0);
    run_op(32'd1000, 32'd3, 1'b0, 2, 3, 1'b1);

    // Zero divisor
`ifdef DIV_ZERO_DETECT_EN
    s0 = starts;
    @(negedge clk);
    req = 1'b1; rs_val = 32'd5; rt_val = 32'd0; is_signed = 1'b0;
    @(negedge clk);
    req = 1'b0;
    check_eq("z_start", {31'd0, div_start}, 32'd0);
    check_eq("z_stall", {31'd0, stall}, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("z_lo", lo_out, 32'hFFFF_FFFF);
    check_eq("z_flag", {31'd0, div_zero}, 32'd1);
    check_eq("z_nostart", starts, s0);
    check_eq("z_idle", {31'd0, stall}, 32'd0);
    $display("op rs=00000005 rt=00000000 zero-detect -> lo=%08h div_zero=%0d", lo_out, div_zero);
`else
    run_op(32'd5, 32'd0, 1'b0, 2, 1, 1'b0);
    check_eq("z_flag", {31'd0, div_zero}, 32'd0);
`endif

    // Reset in the middle of WAIT, then a stale done from the divider
    lat_cfg = 12; hold_cfg = 1;
    @(negedge clk);
    req = 1'b1; rs_val = 32'd77; rt_val = 32'd5; is_signed = 1'b0;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_start", {31'd0, div_start}, 32'd0);
    check_eq("abort_stall", {31'd0, stall}, 32'd0);
    check_eq("abort_lo", lo_out, 32'd0);
    check_eq("abort_op1", div_op1, 32'd0);
    check_eq("abort_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = starts;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall || lo_out != 0) seen = 1'b1;
    end
    check_eq("stale_done", {31'd0, seen}, 32'd0);
    check_eq("stale_start", starts, s0);
    $display("op abort during WAIT -> lo=%08h stall=%0d", lo_out, stall);
    run_op(32'd77, 32'd5, 1'b0, 3, 1, 1'b0);

    // Randomized operations
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(1, 20);
        1: rb = -$urandom_range(1, 20);
        2: ra = $urandom_range(0, 1000);
        default: ;
      endcase
      if (rb == 0) rb = 32'd1;
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(1, 8),
             $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
